ccta_op_issuer: RTL and testbench

// Driver-side companion to the CCTA datapath. Accepts operand triples (A,B,C) plus

---
 rtl/ccta_op_issuer.sv | 155 +++++++++++++++
 tb/tb_ccta_op_issuer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccta_op_issuer.sv
// Operand issuer for a CCTA datapath: buffers operand triples in a FIFO, presents them one at a
// time, samples the CCTA result after a settle time and returns it over a valid/ready port.
module ccta_op_issuer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_c,
    input  logic       in_ctrl,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic [3:0] c_o,
    output logic       ctrl_o,
    input  logic [4:0] q_i,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_q,
    output logic       res_ctrl,
    output logic [7:0] done_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] FullCnt    = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] SettleInit = CW'(SETTLE - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StResult = 2'd2;

    logic [12:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [3:0]    a_q, a_d, b_q, b_d, c_q, c_d;
    logic          ctrl_q, ctrl_d;
    logic          valid_q, valid_d;
    logic [4:0]    result_q, result_d;
    logic          rctrl_q, rctrl_d;
    logic [7:0]    done_q, done_d;
    logic [12:0]   head;
    logic          push, pop, empty;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FullCnt);
    assign push     = in_valid & in_ready;
    assign pop      = (state_q == StIdle) & ~empty;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        result_d = result_q;
        rctrl_d  = rctrl_q;
        done_d   = done_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    {a_d, b_d, c_d, ctrl_d} = head;
                    settle_d = SettleInit;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                // q_i is only trusted on the last settle edge
                if (settle_q == '0) begin
                    result_d = q_i;
                    rctrl_d  = ctrl_q;
                    valid_d  = 1'b1;
                    state_d  = StResult;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            StResult: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    done_d  = done_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_c, in_ctrl};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            ctrl_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rctrl_q  <= 1'b0;
            done_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rctrl_q  <= rctrl_d;
            done_q   <= done_d;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign c_o       = c_q;
    assign ctrl_o    = ctrl_q;
    assign res_valid = valid_q;
    assign res_q     = result_q;
    assign res_ctrl  = rctrl_q;
    assign done_cnt  = done_q;

endmodule

// File: tb/tb_ccta_op_issuer.sv
// Bench for ccta_op_issuer: three instances (SETTLE=1,2,3) share stimulus; each test checks one.
module tb_ccta_op_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ctrl, res_ready, force_en;
    logic [3:0] in_a, in_b, in_c;
    logic [4:0] q_force;
    logic [2:0] in_ready_w, ctrl_w, res_valid_w, res_ctrl_w;
    logic [2:0][3:0] a_w, b_w, c_w;
    logic [2:0][4:0] q_w, res_q_w;
    logic [2:0][7:0] done_w;

    int cur = 0;
    int nchecks = 0;
    int nfail = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       ctl;
        logic [4:0] q;
    } vec_t;

    vec_t tbl[5];
    logic [5:0] expq[$];
    int consumed = 0;
    logic held_v = 1'b0;
    logic [5:0] held = '0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            // CCTA stub; instance 1 can have q_i overridden to probe the sample point
            assign q_w[g] = (force_en && g == 1) ? q_force : {1'b0, a_w[g]} + {1'b0, b_w[g]};
            ccta_op_issuer #(.DEPTH(4), .SETTLE(g + 1)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid),
                .in_ready (in_ready_w[g]),
                .in_a     (in_a),
                .in_b     (in_b),
                .in_c     (in_c),
                .in_ctrl  (in_ctrl),
                .a_o      (a_w[g]),
                .b_o      (b_w[g]),
                .c_o      (c_w[g]),
                .ctrl_o   (ctrl_w[g]),
                .q_i      (q_w[g]),
                .res_valid(res_valid_w[g]),
                .res_ready(res_ready),
                .res_q    (res_q_w[g]),
                .res_ctrl (res_ctrl_w[g]),
                .done_cnt (done_w[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_all();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; force_en = 1'b0; q_force = '0;
        in_a = '0; in_b = '0; in_c = '0; in_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge just after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic ctl);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_ctrl = ctl;
        while (!in_ready_w[cur] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_w[cur]) chk("push_ready_timeout", 32'(in_ready_w[cur]), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int bound);
        int n = 0;
        while (!res_valid_w[cur] && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid_w[cur]) chk("res_valid_timeout", 32'(res_valid_w[cur]), 1);
    endtask

    task automatic model_step(input logic drive_rand);
        if (drive_rand) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_c      = 4'($urandom);
            in_ctrl   = 1'($urandom);
            res_ready = ($urandom_range(0, 9) < 6);
        end else begin
            in_valid  = 1'b0;
            res_ready = 1'b1;
        end
        if (held_v) chk("rnd_hold", {res_valid_w[0], res_ctrl_w[0], res_q_w[0]}, {1'b1, held});
        chk("rnd_done_cnt", done_w[0], 32'(consumed[7:0]));
        if (expq.size() == 0) begin
            chk("rnd_ready_empty", 32'(in_ready_w[0]), 1);
            chk("rnd_no_result", 32'(res_valid_w[0]), 0);
        end
        if (expq.size() >= 5) chk("rnd_ready_full", 32'(in_ready_w[0]), 0);
        held_v = 1'b0;
        if (res_valid_w[0] && expq.size() > 0) begin
            if (res_ready) begin
                chk("rnd_result", {res_ctrl_w[0], res_q_w[0]}, expq.pop_front());
                consumed++;
            end else begin
                held_v = 1'b1;
                held   = {res_ctrl_w[0], res_q_w[0]};
            end
        end
        if (in_valid && in_ready_w[0]) expq.push_back({in_ctrl, {1'b0, in_a} + {1'b0, in_b}});
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] t3a[6];
        logic [3:0] t3b[6];
        logic [4:0] t3q[6];
        int bad_q, bad_gap, nres, pushes, last, cyc, k, acc_k, any_valid;
        logic acc, take;

        tbl[0] = '{a: 4'h4, b: 4'h1, c: 4'h9, ctl: 1'b0, q: 5'h05};
        tbl[1] = '{a: 4'hf, b: 4'hf, c: 4'h0, ctl: 1'b1, q: 5'h1e};
        tbl[2] = '{a: 4'h0, b: 4'h0, c: 4'h3, ctl: 1'b1, q: 5'h00};
        tbl[3] = '{a: 4'h8, b: 4'h7, c: 4'h2, ctl: 1'b0, q: 5'h0f};
        tbl[4] = '{a: 4'ha, b: 4'h3, c: 4'h5, ctl: 1'b1, q: 5'h0d};
        t3a = '{4'h3, 4'h5, 4'hd, 4'hd, 4'h6, 4'h5};
        t3b = '{4'hd, 4'h2, 4'h6, 4'hc, 4'h5, 4'h7};
        t3q = '{5'h10, 5'h07, 5'h13, 5'h19, 5'h0b, 5'h0c};

        // Reset values
        cur = 0;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; force_en = 1'b0; q_force = '0;
        in_a = '0; in_b = '0; in_c = '0; in_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_w[0]), 1);
        chk("rst_drive", {a_w[0], b_w[0], c_w[0], ctrl_w[0]}, 0);
        chk("rst_res", {res_valid_w[0], res_ctrl_w[0], res_q_w[0]}, 0);
        chk("rst_done", done_w[0], 0);
        rst = 1'b0;
        any_valid = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid_w[0]) any_valid++;
        end
        chk("idle_no_result", any_valid, 0);

        // Single operations, fixed latency
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ctl);
            @(negedge clk);
            chk("single_early", 32'(res_valid_w[0]), 0);
            @(negedge clk);
            chk("single_valid", 32'(res_valid_w[0]), 1);
            chk("single_q", res_q_w[0], 32'(tbl[i].q));
            chk("single_ctrl", 32'(res_ctrl_w[0]), 32'(tbl[i].ctl));
            @(negedge clk);
            chk("single_done", done_w[0], 32'(i + 1));
            chk("single_cleared", 32'(res_valid_w[0]), 0);
        end

        // Full FIFO and result backpressure
        reset_all();
        cur = 0;
        for (int i = 0; i < 5; i++) push(t3a[i], t3b[i], 4'h0, 1'(i));
        chk("bp_full", 32'(in_ready_w[0]), 0);
        chk("bp_valid", 32'(res_valid_w[0]), 1);
        chk("bp_q", res_q_w[0], 32'h10);
        in_valid = 1'b1; in_a = t3a[5]; in_b = t3b[5]; in_c = '0; in_ctrl = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_still_full", 32'(in_ready_w[0]), 0);
            chk("bp_q_held", res_q_w[0], 32'h10);
        end
        res_ready = 1'b1;
        k = 0; acc_k = -1;
        for (int n = 0; n < 60 && k < 6; n++) begin
            acc  = in_valid & in_ready_w[0];
            take = res_valid_w[0] & res_ready;
            if (acc) acc_k = k;
            if (take) begin
                chk("bp_order", res_q_w[0], 32'(t3q[k]));
                k++;
            end
            @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count", k, 6);
        chk("bp_sixth_after_pop", 32'(acc_k >= 1), 1);
        chk("bp_done", done_w[0], 6);

        // Long run with SETTLE=3: spacing, counter wrap
        reset_all();
        cur = 2; res_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'hf; in_b = 4'hf; in_c = '0; in_ctrl = 1'b0;
        pushes = 0; nres = 0; last = 0; bad_q = 0; bad_gap = 0; cyc = 0;
        while (nres < 300 && cyc < 3000) begin
            if (in_valid && in_ready_w[2]) pushes++;
            if (res_valid_w[2]) begin
                if (res_q_w[2] !== 5'h1e) bad_q++;
                if (nres > 0 && cyc - last != 5) bad_gap++;
                last = cyc;
                nres++;
            end
            @(negedge clk);
            cyc++;
            if (pushes >= 300) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("wrap_nres", nres, 300);
        chk("wrap_pushes", pushes, 300);
        chk("wrap_bad_q", bad_q, 0);
        chk("wrap_bad_gap", bad_gap, 0);
        chk("wrap_done", done_w[2], 44);
        chk("wrap_empty", 32'(in_ready_w[2]), 1);

        // Sample point with SETTLE=2
        reset_all();
        cur = 1; res_ready = 1'b1; force_en = 1'b1; q_force = 5'h1f;
        push(4'h3, 4'h4, 4'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("sample_not_yet", 32'(res_valid_w[1]), 0);
        q_force = 5'h0a;
        @(negedge clk);
        q_force = 5'h1f;
        chk("sample_valid", 32'(res_valid_w[1]), 1);
        chk("sample_q", res_q_w[1], 32'h0a);
        chk("sample_ctrl", 32'(res_ctrl_w[1]), 1);
        force_en = 1'b0;

        // Reset while settling
        reset_all();
        cur = 2; res_ready = 1'b1;
        push(4'h1, 4'h2, 4'h0, 1'b0);
        wait_res(20);
        @(negedge clk);
        chk("midrst_pre_done", done_w[2], 1);
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'(i + 2), 4'h1, 4'h0, 1'b1);
        chk("midrst_settling", 32'(res_valid_w[2]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(in_ready_w[2]), 1);
        chk("midrst_valid", 32'(res_valid_w[2]), 0);
        chk("midrst_done", done_w[2], 0);
        chk("midrst_drive", {a_w[2], b_w[2]}, 0);
        repeat (6) @(negedge clk);
        chk("midrst_no_leftover", {res_valid_w[2], a_w[2], b_w[2]}, 0);
        res_ready = 1'b1;
        push(4'h8, 4'h5, 4'h0, 1'b0);
        wait_res(20);
        chk("midrst_after_q", res_q_w[2], 32'h0d);

        // Randomized traffic against the transaction model
        reset_all();
        cur = 0; consumed = 0; held_v = 1'b0;
        expq.delete();
        for (int i = 0; i < 1500; i++) model_step(1'b1);
        for (int i = 0; i < 100 && expq.size() > 0; i++) model_step(1'b0);
        chk("rnd_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
